// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready handshaked ALU with registered result and Z/V/N/C flags.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for ALUop 110.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       status,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_next, start_state;
    logic             handshake, is_mul;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign handshake = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state == MUL);

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [CW-1:0]    count;
    logic             mul_last;

    assign is_mul   = (ALUop == 3'b110);
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (count == CW'(WIDTH - 1));
`else
    assign is_mul = 1'b0;
`endif

    assign start_state = is_mul ? MUL : HOLD;

    // Single-cycle operations; flags are derived from res below.
    always_comb begin
        add_ext = {1'b0, Ain} + {1'b0, Bin};
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (ALUop)
            3'b000: begin
                res   = add_ext[WIDTH-1:0];
                res_c = add_ext[WIDTH];
                res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
            end
            3'b001: begin
                res   = Ain - Bin;
                res_c = (Ain >= Bin);
                res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
            end
            3'b010:  res = Ain & Bin;
            3'b011:  res = ~Bin;
            3'b100:  res = Ain | Bin;
            3'b101:  res = Ain ^ Bin;
            3'b111:  res = Ain << Bin[SW-1:0];
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = start_state;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            MUL: begin
                if (mul_last) begin
                    state_next = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    state_next = in_valid ? start_state : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out    <= '0;
            status <= '0;
`ifdef ALU_PIPE_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
`endif
        end else begin
            if (handshake && !is_mul) begin
                out    <= res;
                status <= {res_c, res[WIDTH-1], res_v, (res == '0)};
            end
`ifdef ALU_PIPE_MUL_EN
            // Operands are latched at the handshake; one shift-add step per MUL cycle.
            if (handshake && is_mul) begin
                mcand  <= Ain;
                mplier <= Bin;
                acc    <= '0;
                count  <= '0;
            end else if (state == MUL) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_next;
                count  <= count + 1'b1;
                if (mul_last) begin
                    out    <= acc_next;
                    status <= {1'b0, acc_next[WIDTH-1], 1'b0, (acc_next == '0)};
                end
            end
`endif
        end
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have ports Ain, Bin  input  WIDTH  operands.
REQ-007 SHALL have port ALUop  input  3  operation code.
REQ-008 SHALL have port out_valid  output  1  result held and valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port out  output  WIDTH  registered result.
REQ-011 SHALL have port status  output  4  registered flags: [0] Z, [1] V, [2] N, [3] C.
REQ-012 SHALL have port busy  output  1  high in state MUL.

Function
REQ-013 SHALL decode ALUop as follows: 000 A+B, 001 A-B, 010 A&B, 011 ~B, 100 A|B, 101 A^B, 110 A*B (low WIDTH bits), 111 A<<B[clog2(WIDTH)-1:0].
REQ-014 SHALL capture a request on a rising edge where in_valid and in_ready are both high (the handshake).
REQ-015 SHALL implement FSM states IDLE, MUL, HOLD, with reset state IDLE.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==HOLD & out_ready).
REQ-017 SHALL, on a handshake with ALUop≠110, register out and status and enter HOLD: latency 1 cycle.
REQ-018 SHALL, on a handshake with ALUop=110, enter MUL and run an iterative shift-add over exactly WIDTH cycles, then register the result and enter HOLD: latency WIDTH+1 cycles.
REQ-019 SHALL assert out_valid only in HOLD, holding out and status stable until out_ready.
REQ-020 SHALL, in HOLD with out_ready and no new handshake, return to IDLE and deassert out_valid.
REQ-021 SHALL, in HOLD with out_ready and in_valid both high, accept the new request in that same cycle (back-to-back operation, no bubble).
REQ-022 SHALL ignore in_valid while in MUL, and operand changes after the handshake.
REQ-023 SHALL set Z = (result==0) and N = result[WIDTH-1] for every op.
REQ-024 SHALL set V to signed overflow and C to carry-out for add, and C to no-borrow (A>=B unsigned) for sub; SHALL clear V and C for all other ops.
REQ-025 SHALL drop bits above WIDTH with no saturation for add, sub, mul and shift.

Reset
REQ-026 SHALL, while reset_n is low, force state=IDLE, out=0, status=0, out_valid=0 and busy=0; in_ready SHALL follow REQ-016 and therefore read 1.
REQ-027 SHALL, when reset is asserted mid-MUL or in HOLD, abort the operation without emitting a result; the first handshake SHALL be possible on the first edge after release.

Configuration
REQ-028 SHALL compile the iterative multiplier only when macro ALU_PIPE_MUL_EN is defined.
REQ-029 SHALL, without ALU_PIPE_MUL_EN, treat ALUop=110 as a 1-cycle op yielding out=0 and status=0001 (Z only); MUL state and busy SHALL then stay low.

Verification
REQ-030 SHALL cover: WIDTH=16, sub 0x0005-0x0005 -> out=0x0000, status=1001 (C,Z) one cycle after handshake.
REQ-031 SHALL cover: WIDTH=16, add 0x7FFF+0x0001 -> out=0x8000, status=0110 (N,V).
REQ-032 SHALL cover: WIDTH=16 with ALU_PIPE_MUL_EN, mul 0x0012*0x0034 -> out=0x03A8 after exactly 17 cycles; busy high for 16 cycles; in_valid during MUL ignored.
REQ-033 SHALL cover: out_ready held low for 5 cycles -> out, status and out_valid stable; then out_ready and in_valid both high -> new op accepted in that same cycle.
REQ-034 SHALL cover: reset_n pulsed low in cycle 4 of a mul -> outputs zero immediately, no out_valid afterwards; next add 0x0001+0x0002 -> 0x0003.
REQ-035 SHALL cover: WIDTH=8, shl 0x81 by 1 -> out=0x02, status=0000; without ALU_PIPE_MUL_EN, op 110 -> out=0x00, status=0001.
